// File: rtl/golomb_pkg.sv
// Shared constants and helpers for the Golomb-Rice stream decoder.
package golomb_pkg;

   localparam int DEF_IN_W  = 32;
   localparam int DEF_BUF_W = 64;
   localparam int DEF_K_W   = 3;
   localparam int DEF_QMAX  = 23;
   localparam int DEF_ESC_W = 8;
   localparam int DEF_N_W   = 12;

   // Widest head the leading-zero counter can scan.
   localparam int LZ_MAX = 64;

   // Longest code the decoder can ever see: escape or longest normal symbol.
   function automatic int max_code_len(input int qmax, input int esc_w, input int k_w);
      int esc_len;
      int norm_len;
      esc_len  = qmax + esc_w;
      norm_len = qmax + (1 << k_w) - 1;
      return (esc_len > norm_len) ? esc_len : norm_len;
   endfunction

   // Width of the untruncated decoded value (covers both symbol kinds).
   function automatic int nfull_width(input int qmax, input int k_w, input int esc_w);
      int w_norm;
      int w_esc;
      w_norm = $clog2(qmax + 1) + (1 << k_w) - 1 + 1;
      w_esc  = esc_w + 1;
      return (w_norm > w_esc) ? w_norm : w_esc;
   endfunction

   // Leading zeros of a left-aligned vector, saturating at cap.
   function automatic int lead_zeros(input logic [LZ_MAX-1:0] v, input int cap);
      int  n;
      logic hit;
      n   = 0;
      hit = 1'b0;
      for (int i = LZ_MAX - 1; i >= 0; i--) begin
         if (!hit && n < cap) begin
            if (v[i]) hit = 1'b1;
            else      n++;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/grs_symbol_parse.sv
// Combinational parse of the symbol at the buffer head: prefix, length,
// untruncated value and whether all of its bits are already buffered.
module grs_symbol_parse
   import golomb_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int K_W   = DEF_K_W,
   parameter int QMAX  = DEF_QMAX,
   parameter int ESC_W = DEF_ESC_W,
   parameter int CNT_W = 7,
   parameter int LEN_W = 6,
   parameter int NF_W  = 13
)(
   input  logic [IN_W-1:0]  head,
   input  logic [CNT_W-1:0] cnt,
   input  logic [K_W-1:0]   k,
   output logic [LEN_W-1:0] q,
   output logic [LEN_W-1:0] len,
   output logic [NF_W-1:0]  n_full,
   output logic             complete
);

   int q_i;
   int len_i;

   // Bits past cnt are always zero in the buffer, so a terminator can only be
   // found inside valid data; an all-zero short head reads as an incomplete escape.
   always_comb begin
      q_i      = lead_zeros(LZ_MAX'(head) << (LZ_MAX - IN_W), QMAX);
      len_i    = 0;
      n_full   = '0;
      if (q_i == QMAX) begin
         len_i  = QMAX + ESC_W;
         n_full = NF_W'((head << QMAX) >> (IN_W - ESC_W)) + NF_W'(1);
      end else begin
         len_i  = q_i + 1 + int'(k);
         n_full = (NF_W'(q_i) << k) + NF_W'((head << (q_i + 1)) >> (IN_W - int'(k)));
      end
      complete = int'(cnt) >= len_i;
      q        = LEN_W'(q_i);
      len      = LEN_W'(len_i);
   end

endmodule

// File: rtl/golomb_rice_stream_decoder.sv
// Streaming Golomb-Rice decoder: left-aligned bit buffer fed by packed words,
// one residual per cycle out on a valid/ready port.
module golomb_rice_stream_decoder
   import golomb_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int BUF_W = DEF_BUF_W,
   parameter int K_W   = DEF_K_W,
   parameter int QMAX  = DEF_QMAX,
   parameter int ESC_W = DEF_ESC_W,
   parameter int N_W   = DEF_N_W
)(
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    flush,
   input  logic [IN_W-1:0]         in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [K_W-1:0]          k,
   output logic [N_W-1:0]          out_n,
   output logic                    out_ovf,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [$clog2(BUF_W):0]  buf_cnt
);

   localparam int CNT_W = $clog2(BUF_W) + 1;
   localparam int LEN_W = $clog2(IN_W + 1);
   localparam int NF_W  = nfull_width(QMAX, K_W, ESC_W);

   if (QMAX + ESC_W > IN_W) begin : g_chk_esc
      $error("escape code does not fit in one input word");
   end
   if (max_code_len(QMAX, ESC_W, K_W) > IN_W) begin : g_chk_norm
      $error("longest normal code does not fit in one input word");
   end
   if (BUF_W < 2 * IN_W) begin : g_chk_buf
      $error("bit buffer must hold at least two input words");
   end
   if (IN_W > LZ_MAX) begin : g_chk_lz
      $error("input word wider than the leading-zero counter");
   end

   logic [BUF_W-1:0] buf_q;
   logic [CNT_W-1:0] cnt_q;
   logic [N_W-1:0]   out_n_q;
   logic             out_ovf_q;
   logic             out_valid_q;

   logic [LEN_W-1:0] sym_q;
   logic [LEN_W-1:0] sym_len;
   logic [NF_W-1:0]  sym_n;
   logic             sym_complete;

   logic             fire;
   logic             accept;
   logic [LEN_W-1:0] consume;
   logic [CNT_W-1:0] rem;
   logic [BUF_W-1:0] buf_d;
   logic [CNT_W-1:0] cnt_d;

   grs_symbol_parse #(
      .IN_W  (IN_W),
      .K_W   (K_W),
      .QMAX  (QMAX),
      .ESC_W (ESC_W),
      .CNT_W (CNT_W),
      .LEN_W (LEN_W),
      .NF_W  (NF_W)
   ) u_parse (
      .head     (buf_q[BUF_W-1 -: IN_W]),
      .cnt      (cnt_q),
      .k        (k),
      .q        (sym_q),
      .len      (sym_len),
      .n_full   (sym_n),
      .complete (sym_complete)
   );

   // in_ready looks only at the registered count, never at this cycle's consumption.
   assign in_ready  = (cnt_q <= CNT_W'(BUF_W - IN_W));
   assign accept    = in_valid && in_ready;
   assign fire      = sym_complete && (!out_valid_q || out_ready);

   assign out_n     = out_n_q;
   assign out_ovf   = out_ovf_q;
   assign out_valid = out_valid_q;
   assign buf_cnt   = cnt_q;

   // Next buffer: drop the consumed symbol, then append the new word right
   // behind whatever bits survive this cycle.
   always_comb begin
      consume = fire ? sym_len : '0;
      rem     = cnt_q - CNT_W'(consume);
      buf_d   = buf_q << consume;
      cnt_d   = rem;
      if (accept) begin
         buf_d = buf_d | ((BUF_W'(in_data) << (BUF_W - IN_W)) >> rem);
         cnt_d = rem + CNT_W'(IN_W);
      end
   end

   // Buffer, count and output register; flush wins over every other update.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         buf_q       <= '0;
         cnt_q       <= '0;
         out_n_q     <= '0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         buf_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
         if (fire) begin
            out_n_q     <= N_W'(sym_n);
            out_ovf_q   <= (sym_n >> N_W) != '0;
            out_valid_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // A firing symbol must lie entirely inside the valid bits.
   a_fire_in_range: assert property (@(posedge clk) disable iff (!rstn)
      fire |-> (CNT_W'(sym_len) <= cnt_q && sym_q <= LEN_W'(QMAX)));

endmodule
